// File: rtl/psum_sched.sv
// Partial-sum scheduler: sequences pass-0 writes, middle-pass read-modify-writes and final-pass output streaming.
// Latency per psum after MAC accept: 1 cycle (pass 0), 2 cycles (RD+WR / RD+OUT), 1 cycle to OUT if single-pass; stalls in OUT until out_ready, MAC held off outside WAIT_MAC.
module psum_sched #(
    parameter int PSUM_ADDR_LEN = 4,
    parameter int PASS_LEN      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [PSUM_ADDR_LEN-1:0] num_psum_m1,
    input  logic [PASS_LEN-1:0]      num_pass_m1,
    input  logic                     mac_valid,
    output logic                     mac_ready,
    output logic [PSUM_ADDR_LEN-1:0] psum_addr,
    output logic                     psum_rd_en,
    output logic                     psum_wr_en,
    output logic                     acc_sel,
    output logic                     psum_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_MAC = 3'd1,
        RD       = 3'd2,
        WR       = 3'd3,
        OUT      = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t                   state;
    logic [PSUM_ADDR_LEN-1:0] idx;
    logic [PSUM_ADDR_LEN-1:0] n_m1;
    logic [PASS_LEN-1:0]      pass;
    logic [PASS_LEN-1:0]      p_m1;

    logic last_idx;
    logic last_pass;
    logic first_pass;

    assign last_idx   = (idx == n_m1);
    assign last_pass  = (pass == p_m1);
    assign first_pass = (pass == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            pass  <= '0;
            n_m1  <= '0;
            p_m1  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_m1  <= num_psum_m1;
                        p_m1  <= num_pass_m1;
                        idx   <= '0;
                        pass  <= '0;
                        state <= WAIT_MAC;
                    end
                end
                WAIT_MAC: begin
                    if (mac_valid) begin
                        if (!first_pass)
                            state <= RD;
                        else if (p_m1 != '0)
                            state <= WR;
                        else
                            state <= OUT;
                    end
                end
                RD: begin
                    state <= last_pass ? OUT : WR;
                end
                WR, OUT: begin
                    // WR always advances; OUT only once the sum is taken downstream
                    if (state == WR || out_ready) begin
                        if (!last_idx) begin
                            idx   <= idx + 1'b1;
                            state <= WAIT_MAC;
                        end else if (!last_pass) begin
                            idx   <= '0;
                            pass  <= pass + 1'b1;
                            state <= WAIT_MAC;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Every output is a decode of registered state, so nothing combinational reaches them from inputs
    assign busy       = (state != IDLE);
    assign mac_ready  = (state == WAIT_MAC);
    assign psum_rd_en = (state == RD);
    assign psum_wr_en = (state == WR);
    assign out_valid  = (state == OUT);
    assign done       = (state == DONE);
    assign acc_sel    = (state == WR || state == OUT) && !first_pass;
    assign psum_mode  = busy && !first_pass;
    assign psum_addr  = (state == RD || state == WR || state == OUT) ? idx : '0;

endmodule

// File: tb/tb_psum_sched.sv
// Scoreboarded bench for psum_sched: a job-level reference model predicts every buffer access and final sum.
module tb_psum_sched;
    localparam int AW = 4;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] num_psum_m1 = '0;
    logic [PW-1:0] num_pass_m1 = '0;
    logic          mac_valid = 1'b0;
    logic          mac_ready;
    logic [AW-1:0] psum_addr;
    logic          psum_rd_en, psum_wr_en, acc_sel, psum_mode, out_valid;
    logic          out_ready = 1'b1;
    logic          busy, done;
    logic [15:0]   mac_data = '0;

    always #5 clk = ~clk;

    psum_sched #(.PSUM_ADDR_LEN(AW), .PASS_LEN(PW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .num_psum_m1(num_psum_m1), .num_pass_m1(num_pass_m1),
        .mac_valid(mac_valid), .mac_ready(mac_ready),
        .psum_addr(psum_addr), .psum_rd_en(psum_rd_en), .psum_wr_en(psum_wr_en),
        .acc_sel(acc_sel), .psum_mode(psum_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    // kind: 0 read, 1 write, 2 output handshake, 3 done pulse
    typedef struct {
        int     kind;
        int     addr;
        bit     acc;
        bit     mode;
        longint sum;
        int     lat;
    } ev_t;

    ev_t    sb[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0, acc_cyc = 0, out_start = 0, done_cnt = 0, stall_cnt = 0;
    longint mac_lat = 0, rd_q = 0, add_v = 0;
    longint pbuf[16];
    bit     prev_stall = 0, prev_hs = 0, prev_acc = 0;
    logic [AW-1:0] prev_addr = '0;
    int     ready_mode = 0;
    bit     abort = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pop_chk(input int kind, input longint sum, input int lat);
        ev_t e;
        if (sb.size() == 0) begin
            chk("unexpected_event_kind", kind, -1);
            return;
        end
        e = sb.pop_front();
        chk("ev_kind", kind, e.kind);
        if (kind == 3) return;
        chk("ev_addr", psum_addr, e.addr);
        chk("ev_mode", psum_mode, e.mode);
        chk("ev_latency", lat, e.lat);
        if (kind != 0) chk("ev_acc_sel", acc_sel, e.acc);
        if (kind == 2) chk("ev_sum", sum, e.sum);
    endtask

    // Monitor plus a behavioural model of the psum buffer and adder
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 0;
            prev_hs    = 0;
        end else begin
            if (mac_valid && mac_ready) begin
                mac_lat = longint'(mac_data);
                acc_cyc = cyc;
            end
            add_v = mac_lat + (acc_sel ? rd_q : 0);
            if (prev_stall) begin
                chk("stall_out_valid", out_valid, 1);
                chk("stall_addr", psum_addr, prev_addr);
                chk("stall_acc_sel", acc_sel, prev_acc);
                chk("stall_mac_ready", mac_ready, 0);
            end
            if (out_valid && !prev_stall) out_start = cyc;
            if (out_valid && !out_ready) stall_cnt++;
            if (psum_rd_en) begin
                pop_chk(0, 0, cyc - acc_cyc);
                rd_q = pbuf[psum_addr];
            end
            if (psum_wr_en) begin
                pop_chk(1, 0, cyc - acc_cyc);
                pbuf[psum_addr] = add_v;
            end
            if (out_valid && out_ready) pop_chk(2, add_v, out_start - acc_cyc);
            if (done) begin
                done_cnt++;
                pop_chk(3, 0, 0);
                chk("done_after_out_hs", prev_hs, 1);
            end
            prev_stall = out_valid && !out_ready;
            prev_hs    = out_valid && out_ready;
            prev_addr  = psum_addr;
            prev_acc   = acc_sel;
        end
    end

    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) out_ready = 1'b1;
        else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic run_job(input int n, input int p, input bit gaps, input bit pulse);
        logic [15:0] m[16][16];
        longint      tot[16];
        ev_t         e;
        int          d0, t;
        for (int i = 0; i < 16; i++) tot[i] = 0;
        for (int pp = 0; pp <= p; pp++)
            for (int i = 0; i <= n; i++) begin
                m[pp][i] = 16'($urandom_range(0, 65535));
                tot[i] += longint'(m[pp][i]);
            end
        // Expected trace: every psum's access sequence for each pass, then one done
        for (int pp = 0; pp <= p; pp++)
            for (int i = 0; i <= n; i++) begin
                e.addr = i; e.mode = (pp != 0); e.acc = (pp != 0); e.sum = 0;
                if (pp == 0 && p == 0) begin
                    e.kind = 2; e.lat = 1; e.sum = tot[i]; sb.push_back(e);
                end else if (pp == 0) begin
                    e.kind = 1; e.lat = 1; sb.push_back(e);
                end else begin
                    e.kind = 0; e.lat = 1; sb.push_back(e);
                    e.kind = (pp < p) ? 1 : 2; e.lat = 2;
                    if (pp == p) e.sum = tot[i];
                    sb.push_back(e);
                end
            end
        e.kind = 3; e.addr = 0; e.acc = 0; e.mode = 0; e.sum = 0; e.lat = 0;
        sb.push_back(e);
        d0 = done_cnt;
        @(posedge clk); #1;
        num_psum_m1 = AW'(n); num_pass_m1 = PW'(p); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int pp = 0; pp <= p; pp++)
            for (int i = 0; i <= n; i++) begin
                if (!abort) begin
                    if (pulse && pp == 0 && i == 2) begin
                        num_psum_m1 = 4'd1; num_pass_m1 = 4'd0; start = 1'b1;
                        @(posedge clk); #1;
                        start = 1'b0;
                        chk("busy_during_start_pulse", busy, 1);
                    end
                    if (gaps)
                        for (int g = $urandom_range(0, 2); g > 0; g--) begin
                            @(posedge clk); #1;
                        end
                    mac_data = m[pp][i]; mac_valid = 1'b1;
                    t = 0;
                    do begin @(negedge clk); t++; end while (!mac_ready && !abort && t < 200);
                    if (t >= 200) chk("mac_accept_timeout", t, 0);
                    if (!abort) begin @(posedge clk); #1; end
                    mac_valid = 1'b0;
                end
            end
        t = 0;
        while (done_cnt == d0 && !abort && t < 100) begin @(negedge clk); t++; end
        if (!abort) begin
            chk("done_timeout", t < 100, 1);
            @(negedge clk);
            chk("busy_after_done", busy, 0);
            chk("done_count", done_cnt - d0, 1);
            chk("scoreboard_drained", sb.size(), 0);
        end
    endtask

    initial begin
        int s0, t;
        #3;
        chk("reset_outputs", {busy, mac_ready, psum_rd_en, psum_wr_en, acc_sel, psum_mode,
                              out_valid, done, psum_addr}, 0);
        #10 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
        end

        run_job(3, 0, 0, 0);
        run_job(1, 2, 0, 0);

        // Final-pass back-pressure: out_ready low for the first 5 OUT cycles
        ready_mode = 2; out_ready = 1'b0; s0 = stall_cnt;
        fork
            run_job(0, 1, 0, 0);
            begin
                t = 0;
                while (!out_valid && t < 100) begin @(negedge clk); t++; end
                repeat (4) @(negedge clk);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        chk("stall_cycles", stall_cnt - s0, 5);
        ready_mode = 0;

        run_job(15, 1, 1, 1);

        // Asynchronous reset in the middle of pass 1
        fork
            run_job(1, 2, 0, 0);
            begin
                t = 0;
                while (!(psum_rd_en && psum_mode) && t < 300) begin @(negedge clk); t++; end
                chk("rd_pass1_reached", psum_rd_en & psum_mode, 1);
                #2 rst = 1'b1; abort = 1;
                #1 chk("rst_async_outputs", {busy, mac_ready, psum_rd_en, psum_wr_en, acc_sel,
                                             psum_mode, out_valid, done, psum_addr}, 0);
                @(posedge clk); #1;
                sb.delete();
                @(posedge clk); #1;
                rst = 1'b0;
            end
        join
        abort = 0;
        run_job(0, 0, 0, 0);

        ready_mode = 1;
        for (int j = 0; j < 6; j++) run_job($urandom_range(0, 15), $urandom_range(0, 3), 1, 0);
        ready_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/psum_sched.md
# psum_sched

Partial-sum scheduler for the convolution datapath. Sequences accumulation of partial sums across multiple filter/channel passes into the psum buffer:
- pass 0 writes fresh MAC results;
- middle passes read-modify-write;
- the final pass streams accumulated sums to the output instead of writing back.

It owns the psum buffer address, read/write strobes, the accumulate-select to the adder, and the MAC/output handshakes.

## Interface
- PSUM_ADDR_LEN, 4, psum buffer address width; buffer depth 2^PSUM_ADDR_LEN
- PASS_LEN, 4, width of pass counter
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a job; sampled only in IDLE
- num_psum_m1  in  PSUM_ADDR_LEN  psums per pass minus 1; latched on start
- num_pass_m1  in  PASS_LEN  passes minus 1; latched on start
- mac_valid  in  1  datapath has a MAC result; held stable until accepted
- mac_ready  out  1  scheduler accepts MAC result
- psum_addr  out  PSUM_ADDR_LEN  buffer address (current index)
- psum_rd_en  out  1  buffer read strobe; data valid next cycle
- psum_wr_en  out  1  buffer write strobe
- acc_sel  out  1  1: adder = MAC + buffer read data; 0: adder = MAC + 0
- psum_mode  out  1  1 while current pass > 0 (read-modify-write mode)
- out_valid  out  1  adder output is a final sum
- out_ready  in  1  downstream accepts final sum
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at job completion

## Operation
- States: IDLE, WAIT_MAC, RD, WR, OUT, DONE. Registers: idx (PSUM_ADDR_LEN), pass (PASS_LEN), n_m1, p_m1.
- IDLE: on start, latch n_m1 and p_m1, clear idx and pass, go to WAIT_MAC. start is ignored in all other states.
- WAIT_MAC: mac_ready=1. On mac_valid:
  - pass==0 and p_m1!=0 -> WR
  - pass==0 and p_m1==0 -> OUT
  - pass!=0 -> RD
- RD: psum_rd_en=1, psum_addr=idx. Next state is WR if pass!=p_m1, else OUT.
- WR: psum_wr_en=1, psum_addr=idx, acc_sel=(pass!=0). Then advance.
- OUT: out_valid=1, acc_sel=(pass!=0), psum_addr=idx. Holds until out_ready, then advances. acc_sel, psum_addr and the read data from RD stay stable while stalled. No buffer read is reissued, so the buffer must not be written by others during the stall.
- Advance:
  - idx!=n_m1: idx+1, go to WAIT_MAC.
  - idx==n_m1 and pass!=p_m1: idx=0, pass+1, go to WAIT_MAC.
  - idx==n_m1 and pass==p_m1: go to DONE.
- DONE: done=1 for one cycle, then IDLE. busy falls in the same cycle IDLE is entered.
- psum_mode = busy & (pass!=0).
- All strobes are decoded from the state register only; no combinational path from inputs to outputs.
- Counters never wrap:
  - idx is bounded by n_m1; n_m1 = 2^PSUM_ADDR_LEN-1 uses the full buffer.
  - pass is bounded by p_m1.

## Timing
- Reset values: state IDLE; idx, pass, n_m1, p_m1 = 0; every output 0, including psum_addr.
- Reset mid-job: immediate return to IDLE, all strobes drop asynchronously. Buffer contents are don't-care; a new start is required.
- Per-psum latency from mac_valid&mac_ready:
  - pass 0 (not last): 1 cycle to WR.
  - middle pass: RD then WR, 2 cycles.
  - final pass: RD then OUT, out_valid 2 cycles after accept; 1 cycle if single-pass.
- Minimum throughput, one psum per:
  - pass 0: 2 cycles
  - middle pass: 3 cycles
  - final pass: 3 cycles with out_ready held high
- mac_ready is high only in WAIT_MAC. A mac_valid in other states is held off, never dropped.
- Single-psum, single-pass job (n_m1=0, p_m1=0): IDLE -> WAIT_MAC -> OUT -> DONE.
- done asserts in the cycle after the final OUT handshake.

## Test plan
- Reset/idle: rst pulse mid-cycle -> all outputs 0 asynchronously; start=0 for 10 cycles -> busy stays 0.
- Single pass, n_m1=3, p_m1=0, mac_valid always 1, out_ready=1:
  - 4 out_valid pulses at psum_addr 0,1,2,3, each with acc_sel=0;
  - no rd_en/wr_en;
  - done 1 cycle after last OUT.
- Three passes, n_m1=1, p_m1=2:
  - pass 0: wr_en at addr 0,1 with rd_en=0 and psum_mode=0;
  - pass 1: rd_en then wr_en at addr 0, then addr 1, with psum_mode=1 and acc_sel=1;
  - pass 2: rd_en then out_valid at addr 0, then addr 1;
  - exactly 2 out_valid pulses;
  - datapath model sums match the reference accumulation.
- Back-pressure: final pass with out_ready held 0 for 5 cycles -> out_valid, psum_addr, acc_sel stable, mac_ready=0; release -> advances 1 cycle later.
- Boundary: n_m1=2^PSUM_ADDR_LEN-1, p_m1=1 -> addresses 0..max without wrap in both passes; start pulsed while busy -> ignored, job count unchanged.
- Reset mid-job: assert rst during pass 1 RD -> IDLE with all outputs 0; new job n_m1=0, p_m1=0 completes normally.
